// File: rtl/sram_resp.sv
// sram_resp: single-cycle SRAM responder serving a CPU's instruction and
// data SRAM ports from one shared word RAM, plus a small data-side MMIO block.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   inst_sram_*           - instruction port (read-only; wen/wdata ignored)
//   data_sram_*           - data port (byte-enabled writes, 1-cycle reads)
//   led                   - LED register output (MMIO 0xF000)
//   switch                - switch levels (MMIO 0xF020, read-only)
module sram_resp #(
    parameter int          MEM_AW    = 14,
    parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch
);

    localparam logic [15:0] OFF_LED   = 16'hF000;
    localparam logic [15:0] OFF_NUM   = 16'hF010;
    localparam logic [15:0] OFF_SW    = 16'hF020;
    localparam logic [15:0] OFF_TIMER = 16'hE000;

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    logic [MEM_AW-1:0] i_idx;
    logic [MEM_AW-1:0] d_idx;
    logic [15:0]       d_off;
    logic              d_mmio;
    logic              d_rd;
    logic              d_wr;
    logic [31:0]       mmio_rdata;
    logic [31:0]       num;
    logic [31:0]       timer;
    logic [15:0]       led_q;
    logic [31:0]       led_merged;

    // High/low address bits outside the word index are don't-care (aliasing).
    logic unused_bits;
    assign unused_bits = ^{inst_sram_wen, inst_sram_wdata,
                           inst_sram_addr[31:MEM_AW+2], inst_sram_addr[1:0]};

    assign i_idx  = inst_sram_addr[MEM_AW+1:2];
    assign d_idx  = data_sram_addr[MEM_AW+1:2];
    assign d_off  = data_sram_addr[15:0];
    assign d_mmio = (data_sram_addr[31:16] == MMIO_BASE);
    assign d_rd   = data_sram_en && (data_sram_wen == 4'b0000);
    assign d_wr   = data_sram_en && (data_sram_wen != 4'b0000);
    assign led    = led_q;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    assign led_merged = byte_merge({16'h0000, led_q}, data_sram_wdata,
                                   {2'b00, data_sram_wen[1:0]});

    always_comb begin
        mmio_rdata = 32'h0;
        case (d_off)
            OFF_LED:   mmio_rdata = {16'h0000, led_q};
            OFF_NUM:   mmio_rdata = num;
            OFF_SW:    mmio_rdata = {24'h0, switch};
            OFF_TIMER: mmio_rdata = timer;
            default:   mmio_rdata = 32'h0;
        endcase
    end

    // RAM write port: no reset so it maps onto block RAM; old data is read
    // by the read ports on the same edge (read-before-write).
    always_ff @(posedge clk) begin
        if (!rst && d_wr && !d_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i])
                    mem[d_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
        end else begin
            if (inst_sram_en)
                inst_sram_rdata <= mem[i_idx];
            if (d_rd)
                data_sram_rdata <= d_mmio ? mmio_rdata : mem[d_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 16'h0;
            num   <= 32'h0;
            timer <= 32'h0;
        end else begin
            // A timer write replaces this cycle's increment.
            if (d_wr && d_mmio && d_off == OFF_TIMER)
                timer <= byte_merge(timer, data_sram_wdata, data_sram_wen);
            else
                timer <= timer + 32'd1;
            if (d_wr && d_mmio && d_off == OFF_LED)
                led_q <= led_merged[15:0];
            if (d_wr && d_mmio && d_off == OFF_NUM)
                num <= byte_merge(num, data_sram_wdata, data_sram_wen);
        end
    end

endmodule

// File: tb/tb_sram_resp.sv
// tb_sram_resp: self-checking bench for sram_resp with directed scenarios
// and randomized traffic against a behavioural memory/MMIO model.
module tb_sram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ien;
    logic [3:0]  iwen;
    logic [31:0] iaddr;
    logic [31:0] iwdata;
    logic [31:0] irdata;
    logic        den;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] drdata;
    logic [15:0] led;
    logic [7:0]  sw;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    logic [31:0] mmem [int];
    logic [31:0] m_ird, m_drd, m_num, m_timer;
    logic [15:0] m_led;
    bit          i_known, d_known;

    sram_resp dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(ien), .inst_sram_wen(iwen),
        .inst_sram_addr(iaddr), .inst_sram_wdata(iwdata),
        .inst_sram_rdata(irdata),
        .data_sram_en(den), .data_sram_wen(dwen),
        .data_sram_addr(daddr), .data_sram_wdata(dwdata),
        .data_sram_rdata(drdata),
        .led(led), .switch(sw)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FFF);
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] o,
                                           input logic [31:0] w,
                                           input logic [3:0]  be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) m = m | (32'hFF << (8 * i));
        return (o & ~m) | (w & m);
    endfunction

    function automatic logic [31:0] mmio_val(input logic [15:0] off);
        case (off)
            16'hF000: return {16'h0, m_led};
            16'hF010: return m_num;
            16'hF020: return {24'h0, sw};
            16'hE000: return m_timer;
            default:  return 32'h0;
        endcase
    endfunction

    // Advance model by one clock using currently driven inputs, then clock.
    task automatic step();
        logic [31:0] nt, tmp;
        bit          mm;
        int          w;
        if (rst) begin
            m_ird = 0; m_drd = 0; i_known = 1; d_known = 1;
            m_led = 0; m_num = 0; m_timer = 0;
        end else begin
            nt = m_timer + 1;
            mm = (daddr[31:16] == 16'hBFAF);
            if (ien) begin
                w = widx(iaddr);
                i_known = mmem.exists(w);
                if (i_known) m_ird = mmem[w];
            end
            if (den && dwen == 4'h0) begin
                if (mm) begin
                    m_drd = mmio_val(daddr[15:0]);
                    d_known = 1;
                end else begin
                    w = widx(daddr);
                    d_known = mmem.exists(w);
                    if (d_known) m_drd = mmem[w];
                end
            end
            if (den && dwen != 4'h0) begin
                if (mm) begin
                    case (daddr[15:0])
                        16'hF000: begin
                            tmp = bmerge({16'h0, m_led}, dwdata, {2'b00, dwen[1:0]});
                            m_led = tmp[15:0];
                        end
                        16'hF010: m_num = bmerge(m_num, dwdata, dwen);
                        16'hE000: nt = bmerge(m_timer, dwdata, dwen);
                        default: ;
                    endcase
                end else begin
                    w = widx(daddr);
                    if (mmem.exists(w))
                        mmem[w] = bmerge(mmem[w], dwdata, dwen);
                    else if (dwen == 4'hF)
                        mmem[w] = dwdata;
                end
            end
            m_timer = nt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ien = 0; iwen = 0; den = 0; dwen = 0;
    endtask

    task automatic dwrite(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        idle(); den = 1; dwen = be; daddr = a; dwdata = d;
    endtask

    task automatic dread(input logic [31:0] a);
        idle(); den = 1; daddr = a;
    endtask

    task automatic test_reset();
        rst = 1; idle(); iaddr = 0; iwdata = 0; daddr = 0; dwdata = 0;
        sw = 8'h00;
        step(); step();
        n_cmp++;
        if (irdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_irdata got %h want 0", irdata);
        end
        n_cmp++;
        if (drdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_drdata got %h want 0", drdata);
        end
        n_cmp++;
        if (led !== 16'h0) begin
            n_bad++; $display("FAIL reset_led got %h want 0", led);
        end
        rst = 0;
    endtask

    task automatic test_basic();
        dwrite(32'h8000_0010, 32'h1122_3344, 4'hF); step();
        dread(32'h8000_0010); step();
        n_cmp++;
        if (drdata !== 32'h1122_3344) begin
            n_bad++; $display("FAIL full_write got %h want 11223344", drdata);
        end
        dwrite(32'h8000_0010, 32'hAABB_CCDD, 4'b0010); step();
        n_cmp++;
        if (drdata !== 32'h1122_3344) begin
            n_bad++; $display("FAIL write_hold got %h want 11223344", drdata);
        end
        dread(32'h8000_0010); step();
        n_cmp++;
        if (drdata !== 32'h1122_CC44) begin
            n_bad++; $display("FAIL byte_write got %h want 1122cc44", drdata);
        end
    endtask

    task automatic test_read_before_write();
        dwrite(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        ien = 1; iaddr = 32'h0000_0010; step();
        n_cmp++;
        if (irdata !== 32'h1122_CC44) begin
            n_bad++; $display("FAIL rbw_old got %h want 1122cc44", irdata);
        end
        idle(); ien = 1; iaddr = 32'h0000_0010; step();
        n_cmp++;
        if (irdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL rbw_new got %h want deadbeef", irdata);
        end
    endtask

    task automatic test_timer();
        dwrite(32'hBFAF_E000, 32'hFFFF_FFFE, 4'hF); step();
        idle(); step();
        dread(32'hBFAF_E000); step();
        n_cmp++;
        if (drdata !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL timer_1 got %h want ffffffff", drdata);
        end
        dread(32'hBFAF_E000); step();
        n_cmp++;
        if (drdata !== 32'h0) begin
            n_bad++; $display("FAIL timer_wrap got %h want 0", drdata);
        end
    endtask

    task automatic test_mmio();
        dwrite(32'hBFAF_F000, 32'hFFFF_1234, 4'hF); step();
        n_cmp++;
        if (led !== 16'h1234) begin
            n_bad++; $display("FAIL led_out got %h want 1234", led);
        end
        dread(32'hBFAF_F000); step();
        n_cmp++;
        if (drdata !== 32'h0000_1234) begin
            n_bad++; $display("FAIL led_read got %h want 00001234", drdata);
        end
        sw = 8'h5A;
        dwrite(32'hBFAF_F020, 32'hFFFF_FFFF, 4'hF); step();
        dread(32'hBFAF_F020); step();
        n_cmp++;
        if (drdata !== 32'h0000_005A) begin
            n_bad++; $display("FAIL switch_read got %h want 0000005a", drdata);
        end
        dwrite(32'h0000_F010, 32'h55AA_55AA, 4'hF); step();
        dwrite(32'hBFAF_F010, 32'hCAFE_F00D, 4'hF); step();
        dwrite(32'hBFAF_F010, 32'h0077_0000, 4'b0100); step();
        dread(32'hBFAF_F010); step();
        n_cmp++;
        if (drdata !== 32'hCA77_F00D) begin
            n_bad++; $display("FAIL num_read got %h want ca77f00d", drdata);
        end
        dwrite(32'hBFAF_1234, 32'h1111_1111, 4'hF); step();
        dread(32'hBFAF_1234); step();
        n_cmp++;
        if (drdata !== 32'h0) begin
            n_bad++; $display("FAIL unmapped got %h want 0", drdata);
        end
        dread(32'h0000_F010); ien = 1; iaddr = 32'hBFAF_F010; step();
        n_cmp++;
        if (drdata !== 32'h55AA_55AA) begin
            n_bad++; $display("FAIL mmio_no_ram got %h want 55aa55aa", drdata);
        end
        n_cmp++;
        if (irdata !== 32'h55AA_55AA) begin
            n_bad++; $display("FAIL inst_in_window got %h want 55aa55aa", irdata);
        end
    endtask

    task automatic test_hold();
        dread(32'h8000_0010); step();
        idle(); dwen = 4'hF; daddr = 32'h8000_0010; dwdata = 32'h0BAD_0BAD;
        iaddr = 32'h0000_F010; step(); step();
        n_cmp++;
        if (drdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL hold_data got %h want deadbeef", drdata);
        end
        n_cmp++;
        if (irdata !== 32'h55AA_55AA) begin
            n_bad++; $display("FAIL hold_inst got %h want 55aa55aa", irdata);
        end
        dread(32'h8000_0010); step();
        n_cmp++;
        if (drdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL en0_no_write got %h want deadbeef", drdata);
        end
    endtask

    task automatic test_reset_mid_write();
        rst = 1;
        dwrite(32'h8000_0010, 32'h1234_5678, 4'hF);
        ien = 1; iaddr = 32'h8000_0010; step();
        n_cmp++;
        if (drdata !== 32'h0 || irdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_rdata got %h/%h want 0/0", drdata, irdata);
        end
        n_cmp++;
        if (led !== 16'h0) begin
            n_bad++; $display("FAIL rst_led got %h want 0", led);
        end
        rst = 0;
        dread(32'hBFAF_E000); step();
        n_cmp++;
        if (drdata !== 32'h0) begin
            n_bad++; $display("FAIL rst_timer got %h want 0", drdata);
        end
        dread(32'h8000_0010); step();
        n_cmp++;
        if (drdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL rst_ram_kept got %h want deadbeef", drdata);
        end
    endtask

    function automatic logic [31:0] rnd_ram_addr();
        logic [31:0] a;
        a = $urandom;
        if (a[31:16] == 16'hBFAF) a[31:16] = 16'h8000;
        a[15:2] = 14'h0100 + 14'($urandom_range(0, 7));
        return a;
    endfunction

    task automatic test_random();
        logic [15:0] offs [5];
        offs[0] = 16'hF000; offs[1] = 16'hF010; offs[2] = 16'hF020;
        offs[3] = 16'hE000; offs[4] = 16'h4444;
        for (int k = 0; k < 8; k++) begin
            dwrite(32'h0000_0400 + 32'(k * 4), $urandom, 4'hF); step();
        end
        for (int c = 0; c < 400; c++) begin
            idle();
            ien = 1'($urandom_range(0, 1));
            iwen = 4'($urandom); iwdata = $urandom;
            iaddr = rnd_ram_addr();
            den = ($urandom_range(0, 9) != 0);
            dwen = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            dwdata = $urandom;
            sw = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                daddr = {16'hBFAF, offs[$urandom_range(0, 4)]};
            else
                daddr = rnd_ram_addr();
            step();
            if (i_known) begin
                n_cmp++;
                if (irdata !== m_ird) begin
                    n_bad++;
                    $display("FAIL rnd_inst cyc %0d got %h want %h", c, irdata, m_ird);
                end
            end
            if (d_known) begin
                n_cmp++;
                if (drdata !== m_drd) begin
                    n_bad++;
                    $display("FAIL rnd_data cyc %0d got %h want %h", c, drdata, m_drd);
                end
            end
            n_cmp++;
            if (led !== m_led) begin
                n_bad++;
                $display("FAIL rnd_led cyc %0d got %h want %h", c, led, m_led);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_read_before_write();
        test_timer();
        test_mmio();
        test_hold();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_resp.md
SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 Parameter MEM_AW, default 14: word-address width of the shared backing RAM (2^MEM_AW 32-bit words).
REQ-002 Parameter MMIO_BASE, default 16'hBFAF: value of addr[31:16] that selects the MMIO window on the data port.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 inst_sram_en  input  1  instruction access request.
REQ-006 inst_sram_wen  input  4  instruction byte write enables; always ignored.
REQ-007 inst_sram_addr  input  32  instruction byte address.
REQ-008 inst_sram_wdata  input  32  ignored.
REQ-009 inst_sram_rdata  output  32  instruction read data.
REQ-010 data_sram_en  input  1  data access request.
REQ-011 data_sram_wen  input  4  per-byte write enables; bit i controls wdata[8i+7:8i].
REQ-012 data_sram_addr  input  32  data byte address.
REQ-013 data_sram_wdata  input  32  data write data.
REQ-014 data_sram_rdata  output  32  data read data.
REQ-015 led  output  16  LED register.
REQ-016 switch  input  8  switch levels, sampled as-is.

Function
REQ-017 The block shall respond to both CPU SRAM ports from one shared RAM, with two read ports and one write port.
REQ-018 RAM word index shall be addr[MEM_AW+1:2]; addr[1:0] and addr[31:MEM_AW+2] shall be ignored, and aliasing is accepted.
REQ-019 Read latency shall be exactly 1 cycle: en=1 at edge N gives rdata valid after edge N, held until the next enabled read.
REQ-020 With en=0, rdata shall hold its last value, and any wen value shall cause no write.
REQ-021 A data access with en=1 and wen!=0 shall write only the enabled bytes at the edge, and data_sram_rdata shall hold its previous value.
REQ-022 Same-cycle data write and read of the same word, on either port, shall return the old data (read-before-write).
REQ-023 A data access with addr[31:16]==MMIO_BASE shall go to MMIO only and shall not touch RAM.
REQ-024 MMIO offset 0xF000 is LED, RW: byte enables 0-1 apply; upper read bits are 0.
REQ-025 MMIO offset 0xF010 is NUM, a 32-bit RW register with byte enables.
REQ-026 MMIO offset 0xF020 is SWITCH, RO: reads {24'b0, switch}; writes are ignored.
REQ-027 MMIO offset 0xE000 is TIMER, 32-bit RW: increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
REQ-028 A TIMER write shall load the byte-merged value at that edge instead of incrementing; counting resumes the next cycle.
REQ-029 A TIMER read shall return the value held before the sampling edge.
REQ-030 Other MMIO offsets shall read 0, and writes to them shall be ignored.
REQ-031 Instruction fetches in the MMIO window shall read RAM, since the window is data-port only.

Reset
REQ-032 While rst=1: inst_sram_rdata=0, data_sram_rdata=0, led=0, NUM=0 and TIMER=0 after the edge.
REQ-033 While rst=1, all writes and reads shall be suppressed, and RAM contents are not initialised.
REQ-034 An access presented in the same cycle that rst deasserts shall be serviced normally.

Verification
REQ-035 Scenario: write 0x11223344 to 0x80000010 with wen=4'hF, then read -> rdata=0x11223344 one cycle after the read.
REQ-036 Scenario: write wen=4'b0010, wdata=0xAABBCCDD to the same word -> read returns 0x1122CC44.
REQ-037 Scenario: same cycle, data write 0xDEADBEEF and inst read of word 0x10 -> inst rdata old 0x1122CC44; the next inst read returns 0xDEADBEEF.
REQ-038 Scenario: write TIMER=0xFFFFFFFE, read 1 cycle later -> 0xFFFFFFFF; read 2 cycles later -> 0x00000000.
REQ-039 Scenario: write 0xFFFF1234 to LED -> led=0x1234, LED readback=0x00001234; switch=0x5A -> SWITCH read=0x0000005A.
REQ-040 Scenario: assert rst mid-write (en=1, wen=4'hF) -> RAM word unchanged, rdata=0, led=0, TIMER=0 after the edge.
